// File: rtl/el2_ifu_bp_ras.sv
// Return-address stack for the EL2 fetch branch predictor: circular buffer of
// predicted return targets with checkpoint/restore for mispredict recovery.
module el2_ifu_bp_ras #(
  parameter int DEPTH = 8,
  parameter int AW    = 31,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_push_valid,
  input  logic [AW-1:0] io_push_addr,
  input  logic          io_pop_valid,
  input  logic          io_flush,
  input  logic          io_restore_valid,
  input  logic [PW-1:0] io_restore_ptr,
  input  logic [PW:0]   io_restore_cnt,
  output logic          io_top_valid,
  output logic [AW-1:0] io_top_addr,
  output logic [PW-1:0] io_snap_ptr,
  output logic [PW:0]   io_snap_cnt,
  output logic          io_overflow,
  output logic          io_underflow
);

  // Request semantics: every *_valid input is a single-cycle command sampled on
  // the rising edge; there is no ready, the stack accepts a command every cycle.
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

  logic [AW-1:0] entry_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic          ovf_d, unf_d;
  logic          top_valid_q;
  logic [AW-1:0] top_addr_q, top_addr_d;
  logic          ovf_q, unf_q;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (io_flush) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (io_restore_valid) begin
      ptr_d = io_restore_ptr;
      cnt_d = (io_restore_cnt > FULL) ? FULL : io_restore_cnt;
    end else if (io_push_valid && io_pop_valid) begin
      // A return immediately followed by a call replaces the top in place.
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = CNT_ONE;
    end else if (io_push_valid) begin
      ptr_d  = ptr_q + PTR_ONE;
      wr_en  = 1'b1;
      wr_idx = ptr_q + PTR_ONE;
      if (cnt_q == FULL) ovf_d = 1'b1;
      else               cnt_d = cnt_q + CNT_ONE;
    end else if (io_pop_valid) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PTR_ONE;
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // Top is precomputed from next state so outputs come straight from flops.
  always_comb begin
    top_addr_d = '0;
    if (cnt_d != '0) begin
      if (wr_en && (wr_idx == ptr_d)) top_addr_d = io_push_addr;
      else                            top_addr_d = entry_q[ptr_d];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      top_valid_q <= 1'b0;
      top_addr_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      top_valid_q <= (cnt_d != '0);
      top_addr_q  <= top_addr_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else if (wr_en) begin
      entry_q[wr_idx] <= io_push_addr;
    end
  end

  assign io_top_valid = top_valid_q;
  assign io_top_addr  = top_addr_q;
  assign io_snap_ptr  = ptr_q;
  assign io_snap_cnt  = cnt_q;
  assign io_overflow  = ovf_q;
  assign io_underflow = unf_q;

endmodule
